// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle instruction sequencer with iterative multiply/divide state

typedef logic [6:0] opcode_t;

module multicycle_ctrl #(
    parameter int         MULDIV_EN  = 1,
    parameter int         MD_CYCLES  = 32,
    parameter logic [2:0] CYCLE_INIT = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  opcode_t    opcode,
    input  logic       is_muldiv,
    input  logic       branch_taken,
    input  logic       done,
    input  logic       mem_ready,
    output logic [2:0] cycle,
    output logic       start,
    output logic       rf_wren,
    output logic       mem_rden,
    output logic       mem_wren,
    output logic       md_step,
    output logic       md_last,
    output logic       stall,
    output logic       trap
);

    localparam opcode_t OPC_LOAD   = 7'b0000011;
    localparam opcode_t OPC_FENCE  = 7'b0001111;
    localparam opcode_t OPC_AUIPC  = 7'b0010111;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_OP     = 7'b0110011;
    localparam opcode_t OPC_BRANCH = 7'b1100011;
    localparam opcode_t OPC_JALR   = 7'b1100111;
    localparam opcode_t OPC_JAL    = 7'b1101111;
    localparam opcode_t OPC_SYS    = 7'b1110011;

    localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CW-1:0] MD_LAST_CNT = CW'(MD_CYCLES - 1);
    localparam bit MD_ON = (MULDIV_EN != 0);

    typedef enum logic [2:0] {
        C0 = 3'd0,
        C1 = 3'd1,
        C2 = 3'd2,
        C3 = 3'd3,
        MD = 3'd4
    } state_e;

    localparam state_e INIT_STATE = state_e'(CYCLE_INIT);

    state_e        state_q, state_d;
    logic          start_q, start_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic          mem_req;
    logic          advance;
    logic          moved;

    // Per-state enables, decoded from the current state and the opcode in IR
    always_comb begin
        rf_wren  = 1'b0;
        case (opcode)
            OPC_STORE, OPC_BRANCH, OPC_FENCE: rf_wren = 1'b0;
            OPC_JAL, OPC_AUIPC:               rf_wren = (state_q == C0);
            OPC_LOAD:                         rf_wren = (state_q == C3);
            default:                          rf_wren = (state_q == C2);
        endcase
        mem_rden = ((state_q == C0) && (opcode != OPC_SYS))
                 || ((opcode == OPC_LOAD) && (state_q == C1))
                 || ((opcode == OPC_BRANCH) && (state_q == C2))
                 || ((opcode == OPC_JALR) && (state_q == C2));
        mem_wren = (opcode == OPC_STORE) && (state_q == C1);
        trap     = (state_q == C0) && (opcode == OPC_SYS);
        md_step  = MD_ON && (state_q == MD);
        md_last  = md_step && (md_cnt_q == MD_LAST_CNT);
        mem_req  = mem_rden | mem_wren;
        advance  = done & (mem_ready | ~mem_req);
        stall    = done & mem_req & ~mem_ready;
    end

    // Next state, MD iteration count, and whether this clock leaves the state
    always_comb begin
        state_d  = state_q;
        md_cnt_d = '0;
        moved    = 1'b0;
        case (state_q)
            C0: begin
                // SYS parks here until reset; no request is issued
                if (advance && !trap) begin
                    moved = 1'b1;
                    case (opcode)
                        OPC_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: state_d = C1;
                        default:                                           state_d = C2;
                    endcase
                end
            end
            C1: begin
                if (advance) begin
                    moved = 1'b1;
                    if (opcode == OPC_STORE) begin
                        state_d = C0;
                    end else if (MD_ON && (opcode == OPC_OP) && is_muldiv) begin
                        state_d = MD;
                    end else begin
                        state_d = C2;
                    end
                end
            end
            C2: begin
                if (advance) begin
                    moved = 1'b1;
                    if ((opcode == OPC_LOAD) || ((opcode == OPC_BRANCH) && branch_taken)) begin
                        state_d = C3;
                    end else begin
                        state_d = C0;
                    end
                end
            end
            C3: begin
                if (advance) begin
                    moved   = 1'b1;
                    state_d = C0;
                end
            end
            MD: begin
                // Iterates every clock; done and mem_ready are ignored here
                if (!MD_ON) begin
                    moved   = 1'b1;
                    state_d = C0;
                end else if (md_last) begin
                    moved   = 1'b1;
                    state_d = C2;
                end else begin
                    md_cnt_d = md_cnt_q + CW'(1);
                end
            end
            default: begin
                moved   = 1'b1;
                state_d = C0;
            end
        endcase
        start_d = moved;
    end

    // State, start flag and MD counter registers with asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= INIT_STATE;
            start_q  <= 1'b1;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign cycle = state_q;
    assign start = start_q;

endmodule
